// File: rtl/gcd_sched.sv
// Round-robin scheduler driving a shared subtract-based GCD datapath (optional timeout: GCD_TIMEOUT_EN).
// Latency: done_o pulses k+2 edges after the request is sampled (k = subtractions), 1 edge for zero operands.
// Backpressure: req_i is held until done_o; requests seen while busy wait until the next IDLE cycle.
module gcd_sched #(
    parameter int W        = 4,
    parameter int NREQ     = 4,
    parameter int MAX_ITER = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     req_i,
    input  logic [NREQ*W-1:0]   x_bus_i,
    input  logic [NREQ*W-1:0]   y_bus_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [W-1:0]        x_o,
    output logic [W-1:0]        y_o,
    output logic                x_ld,
    output logic                y_ld,
    output logic                x_sel,
    output logic                y_sel,
    input  logic                x_neq_y,
    input  logic                x_lt_y,
    input  logic [W-1:0]        d_i,
    output logic [W-1:0]        d_o,
    output logic [NREQ-1:0]     done_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CMP  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   g;          // index of the requester currently owning the datapath
    logic [GW-1:0]   rr;         // last requester served; search starts just above it
    logic [GW-1:0]   pick;
    logic [GW-1:0]   cand;
    logic            pick_vld;
    logic [W-1:0]    x_op;
    logic [W-1:0]    y_op;
    logic            op_zero;
    logic            iter_hit;

`ifdef GCD_TIMEOUT_EN
    localparam int CW = $clog2(MAX_ITER) + 1;
    logic [CW-1:0]   iter_cnt;
`endif

    // Round-robin search: first asserted request starting at rr+1, wrapping at NREQ-1.
    always_comb begin
        pick     = rr;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = GW'((int'(rr) + i) % NREQ);
            if (!pick_vld && req_i[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    // Operands of the granted requester; only presented while the datapath is owned.
    always_comb begin
        x_op    = x_bus_i[int'(g)*W +: W];
        y_op    = y_bus_i[int'(g)*W +: W];
        op_zero = (x_op == '0) || (y_op == '0);
        x_o     = (state != IDLE) ? x_op : '0;
        y_o     = (state != IDLE) ? y_op : '0;
        busy_o  = (state != IDLE);
    end

`ifdef GCD_TIMEOUT_EN
    assign iter_hit = (iter_cnt == CW'(MAX_ITER - 1));
`else
    assign iter_hit = 1'b0;
`endif

    // Next state and datapath strobes, decoded from state and the datapath compare flags.
    always_comb begin
        state_nxt = state;
        x_ld      = 1'b0;
        y_ld      = 1'b0;
        x_sel     = 1'b0;
        y_sel     = 1'b0;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                x_ld = 1'b1;
                y_ld = 1'b1;
                // A zero operand makes the other one the answer; skip the subtract loop.
                state_nxt = op_zero ? DONE : CMP;
            end
            CMP: begin
                if (!x_neq_y) begin
                    state_nxt = DONE;
                end else begin
                    // Always subtract the smaller from the larger so nothing underflows.
                    if (x_lt_y) begin
                        y_ld  = 1'b1;
                        y_sel = 1'b1;
                    end else begin
                        x_ld  = 1'b1;
                        x_sel = 1'b1;
                    end
                    if (iter_hit) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State, grant, result and completion registers; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= IDLE;
            g      <= '0;
            rr     <= GW'(NREQ - 1);
            gnt_o  <= '0;
            d_o    <= '0;
            done_o <= '0;
        end else begin
            state  <= state_nxt;
            done_o <= '0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        g     <= pick;
                        gnt_o <= ONE_HOT0 << pick;
                    end
                end
                LOAD: begin
                    if (op_zero) begin
                        d_o <= x_op | y_op;
                    end
                end
                CMP: begin
                    if (!x_neq_y) begin
                        d_o <= d_i;
                    end else if (iter_hit) begin
                        d_o <= '0;
                    end
                end
                DONE: begin
                    rr    <= g;
                    gnt_o <= '0;
                end
                default: begin
                    gnt_o <= '0;
                end
            endcase
            if (state_nxt == DONE) begin
                done_o <= ONE_HOT0 << g;
            end
        end
    end

`ifdef GCD_TIMEOUT_EN
    // Iteration counter and the one-cycle timeout flag shown alongside the DONE pulse.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            iter_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            err_o <= (state == CMP) && x_neq_y && iter_hit;
            if (state == LOAD) begin
                iter_cnt <= '0;
            end else if ((state == CMP) && x_neq_y) begin
                iter_cnt <= iter_cnt + 1'b1;
            end
        end
    end
`else
    assign err_o = 1'b0;
`endif

endmodule
